// File: rtl/gh_pkg.sv
// Shared constants for the note-chart game flow: state encoding, default sizes
// and a small compile-time helper.
package gh_pkg;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_CLEAR   = 3'd1;
    localparam logic [2:0] ENC_COUNTIN = 3'd2;
    localparam logic [2:0] ENC_PLAY    = 3'd3;
    localparam logic [2:0] ENC_DRAIN   = 3'd4;
    localparam logic [2:0] ENC_PAUSE   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = ENC_IDLE,
        ST_CLEAR   = ENC_CLEAR,
        ST_COUNTIN = ENC_COUNTIN,
        ST_PLAY    = ENC_PLAY,
        ST_DRAIN   = ENC_DRAIN,
        ST_PAUSE   = ENC_PAUSE
    } gh_state_t;

    localparam int DEF_STEP_PERIOD = 16777216;
    localparam int DEF_SONG_LEN    = 89;
    localparam int DEF_LANES       = 3;
    localparam int LANE_DEPTH      = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/chart_sequencer_step_timer.sv
// Scroll-step divider: counts 0..PERIOD-1 while running and emits a one-cycle tick
// at PERIOD-1. Hold parks the count at PERIOD-1 instead of wrapping, discarding that tick.
module step_timer
    import gh_pkg::*;
#(
    parameter int PERIOD = DEF_STEP_PERIOD
) (
    input  logic sysclk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_run,
    input  logic i_hold,
    output logic o_tick
);

    localparam int            CW       = $clog2(PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == CNT_LAST);
    assign o_tick    = i_run & ~i_hold & w_at_last;

    // Divider count; frozen when not running, parked at the last value under hold.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run && !w_at_last) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else if (i_run && !i_hold) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/chart_sequencer.sv
// Game-flow controller for the note lanes: clear, count-in, chart playback with
// optional loop, drain, pause/resume and abort. All outputs are registered.
module chart_sequencer
    import gh_pkg::*;
#(
    parameter int STEP_PERIOD   = DEF_STEP_PERIOD,
    parameter int SONG_LEN      = DEF_SONG_LEN,
    parameter int ADDR_W        = 7,
    parameter int LANES         = DEF_LANES,
    parameter int COUNTIN_STEPS = 8,
    parameter int DRAIN_STEPS   = LANE_DEPTH
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause_toggle,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [LANES-1:0]  song_data,
    output logic [ADDR_W-1:0] song_addr,
    output logic              shift_en,
    output logic [LANES-1:0]  shift_bit,
    output logic              lane_clear,
    output logic              playing,
    output logic              paused,
    output logic              song_done
);

    localparam int                SW        = $clog2(max_int(COUNTIN_STEPS, DRAIN_STEPS) + 1);
    localparam logic [SW-1:0]     CIN_LAST  = SW'(COUNTIN_STEPS - 1);
    localparam logic [SW-1:0]     DRN_LAST  = SW'(DRAIN_STEPS - 1);
    localparam logic [SW-1:0]     STEP_ONE  = SW'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    gh_state_t         r_state;
    gh_state_t         r_saved;
    logic [ADDR_W-1:0] r_addr;
    logic [SW-1:0]     r_step;
    logic              r_shift_en;
    logic [LANES-1:0]  r_shift_bit;
    logic              r_lane_clear;
    logic              r_playing;
    logic              r_paused;
    logic              r_song_done;

    logic w_active;
    logic w_tick;

    assign w_active = (r_state == ST_COUNTIN) || (r_state == ST_PLAY) || (r_state == ST_DRAIN);

    step_timer #(
        .PERIOD (STEP_PERIOD)
    ) u_step_timer (
        .sysclk  (sysclk),
        .reset   (reset),
        .i_clear (r_state == ST_CLEAR),
        .i_run   (w_active & ~stop),
        .i_hold  (pause_toggle),
        .o_tick  (w_tick)
    );

    // Game-flow FSM with step/address counters; strobes default low every cycle.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_saved      <= ST_IDLE;
            r_addr       <= '0;
            r_step       <= '0;
            r_shift_en   <= 1'b0;
            r_shift_bit  <= '0;
            r_lane_clear <= 1'b0;
            r_playing    <= 1'b0;
            r_paused     <= 1'b0;
            r_song_done  <= 1'b0;
        end else begin
            r_shift_en   <= 1'b0;
            r_shift_bit  <= '0;
            r_lane_clear <= 1'b0;
            r_song_done  <= 1'b0;
            if (stop && (r_state != ST_IDLE)) begin
                r_state      <= ST_IDLE;
                r_lane_clear <= 1'b1;
                r_addr       <= '0;
                r_step       <= '0;
                r_playing    <= 1'b0;
                r_paused     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state      <= ST_CLEAR;
                            r_lane_clear <= 1'b1;
                            r_addr       <= '0;
                            r_step       <= '0;
                        end
                    end
                    ST_CLEAR: begin
                        r_state   <= ST_COUNTIN;
                        r_step    <= '0;
                        r_playing <= 1'b1;
                    end
                    ST_COUNTIN, ST_PLAY, ST_DRAIN: begin
                        if (pause_toggle) begin
                            r_saved   <= r_state;
                            r_state   <= ST_PAUSE;
                            r_playing <= 1'b0;
                            r_paused  <= 1'b1;
                        end else if (w_tick) begin
                            r_shift_en <= 1'b1;
                            if (r_state == ST_PLAY) begin
                                r_shift_bit <= song_data;
                                if (r_addr >= ADDR_LAST) begin
                                    r_song_done <= 1'b1;
                                    if (loop_en) begin
                                        r_addr <= '0;
                                    end else begin
                                        r_state <= ST_DRAIN;
                                        r_step  <= '0;
                                    end
                                end else begin
                                    r_addr <= r_addr + ADDR_ONE;
                                end
                            end else if (r_state == ST_COUNTIN) begin
                                if (r_step == CIN_LAST) begin
                                    r_state <= ST_PLAY;
                                    r_step  <= '0;
                                end else begin
                                    r_step <= r_step + STEP_ONE;
                                end
                            end else begin
                                if (r_step == DRN_LAST) begin
                                    r_state   <= ST_IDLE;
                                    r_step    <= '0;
                                    r_addr    <= '0;
                                    r_playing <= 1'b0;
                                end else begin
                                    r_step <= r_step + STEP_ONE;
                                end
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (pause_toggle) begin
                            r_state   <= r_saved;
                            r_playing <= 1'b1;
                            r_paused  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_addr    <= '0;
                        r_step    <= '0;
                        r_playing <= 1'b0;
                        r_paused  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign song_addr  = r_addr;
    assign shift_en   = r_shift_en;
    assign shift_bit  = r_shift_bit;
    assign lane_clear = r_lane_clear;
    assign playing    = r_playing;
    assign paused     = r_paused;
    assign song_done  = r_song_done;

endmodule
